// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and the
// pipeline registers that consume its outputs.
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam word_t DEF_NOP      = 32'h0000_0000;
  localparam word_t DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues req/ack fetches, holds a word across IF/ID
// stalls and swallows in-flight responses that a redirect made stale.
import fetch_pkg::*;

module if_fetch_unit #(
  parameter word_t RESET_PC = DEF_RESET_PC,
  parameter word_t NOP      = DEF_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifIdWr,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] pcPlus4,
  output logic [31:0] instruction,
  output logic        fetchValid
);

  fetch_state_t r_state, w_nextState;
  word_t        r_pc, r_dropAddr, r_holdInstr, r_holdPc;
  word_t        w_nextPc, w_nextDrop, w_nextHoldInstr, w_nextHoldPc;
  word_t        w_target;

  assign w_target = branchTarget & ~32'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_dropAddr  <= RESET_PC;
      r_holdInstr <= NOP;
      r_holdPc    <= RESET_PC;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_dropAddr  <= w_nextDrop;
      r_holdInstr <= w_nextHoldInstr;
      r_holdPc    <= w_nextHoldPc;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextDrop      = r_dropAddr;
    w_nextHoldInstr = r_holdInstr;
    w_nextHoldPc    = r_holdPc;
    imemReq         = 1'b0;
    imemAddr        = r_pc;
    fetchValid      = 1'b0;
    instruction     = NOP;
    pcPlus4         = r_pc + 32'd4;

    case (r_state)
      REQ: begin
        imemReq = 1'b1;
        if (imemAck && !pcSrc) begin
          fetchValid  = 1'b1;
          instruction = imemData;
        end
        if (pcSrc) begin
          w_nextPc = w_target;
          if (!imemAck) begin
            w_nextDrop  = r_pc;
            w_nextState = DROP;
          end
        end else if (imemAck) begin
          w_nextPc = r_pc + 32'd4;
          if (!ifIdWr) begin
            w_nextHoldInstr = imemData;
            w_nextHoldPc    = r_pc;
            w_nextState     = HOLD;
          end
        end
      end

      HOLD: begin
        fetchValid  = 1'b1;
        instruction = r_holdInstr;
        pcPlus4     = r_holdPc + 32'd4;
        if (pcSrc) begin
          w_nextPc    = w_target;
          w_nextState = REQ;
        end else if (ifIdWr) begin
          w_nextState = REQ;
        end
      end

      DROP: begin
        // The stale address stays on the bus until its response arrives.
        imemReq  = 1'b1;
        imemAddr = r_dropAddr;
        if (pcSrc) w_nextPc = w_target;
        if (imemAck) w_nextState = REQ;
      end

      default: w_nextState = REQ;
    endcase

    if (rst) begin
      imemReq     = 1'b0;
      fetchValid  = 1'b0;
      instruction = NOP;
      pcPlus4     = RESET_PC + 32'd4;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with hand-computed
// expected outputs, plus a hand-written reset-while-dropping sequence.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifIdWr = 1'b0;
  logic        pcSrc = 1'b0;
  logic [31:0] branchTarget = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] pcPlus4;
  logic [31:0] instruction;
  logic        fetchValid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, wr, src;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eInstr, ePc4;
  } vec_t;

  vec_t vecs[$];

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .ifIdWr(ifIdWr), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .pcPlus4(pcPlus4),
    .instruction(instruction), .fetchValid(fetchValid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic w, logic s, logic [31:0] t,
                              logic a, logic [31:0] d, logic eq,
                              logic [31:0] ea, logic ev, logic [31:0] ei,
                              logic [31:0] ep);
    vec_t v;
    v.rst = r; v.wr = w; v.src = s; v.tgt = t; v.ack = a; v.data = d;
    v.eReq = eq; v.eAddr = ea; v.eValid = ev; v.eInstr = ei; v.ePc4 = ep;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(logic r, logic w, logic s, logic [31:0] t,
                               logic a, logic [31:0] d);
    @(negedge clk);
    rst = r; ifIdWr = w; pcSrc = s; branchTarget = t; imemAck = a; imemData = d;
    #1;
  endtask

  task automatic checkVector(int idx, vec_t v);
    checkOutput($sformatf("v%0d_req", idx), {31'b0, imemReq}, {31'b0, v.eReq});
    if (v.eReq) checkOutput($sformatf("v%0d_addr", idx), imemAddr, v.eAddr);
    checkOutput($sformatf("v%0d_valid", idx), {31'b0, fetchValid}, {31'b0, v.eValid});
    checkOutput($sformatf("v%0d_instr", idx), instruction, v.eInstr);
    checkOutput($sformatf("v%0d_pc4", idx), pcPlus4, v.ePc4);
  endtask

  initial begin
    //            rst wr src tgt          ack data          req addr         vld instr         pc4
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h4));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h99,       0, 32'h0,        0, 32'h0,        32'h4));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hA0,       1, 32'h0,        1, 32'hA0,       32'h4));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hA1,       1, 32'h4,        1, 32'hA1,       32'h8));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hA2,       1, 32'h8,        1, 32'hA2,       32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hA3,       1, 32'hC,        1, 32'hA3,       32'h10));
    // stall at 0x10 for three cycles, then release
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hB0,       1, 32'h10,       1, 32'hB0,       32'h14));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hEE,       0, 32'h0,        1, 32'hB0,       32'h14));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hB0,       32'h14));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hB0,       32'h14));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h14,       0, 32'h0,        32'h18));
    // hold then redirect (low target bits ignored)
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hB1,       1, 32'h14,       1, 32'hB1,       32'h18));
    vecs.push_back(mk(0, 1, 1, 32'h103,      0, 32'h0,        0, 32'h0,        1, 32'hB1,       32'h18));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hC0,       1, 32'h100,      1, 32'hC0,       32'h104));
    // redirect with simultaneous ack: data discarded
    vecs.push_back(mk(0, 1, 1, 32'h20,       1, 32'hD0,       1, 32'h104,      0, 32'h0,        32'h108));
    // slow memory, redirect while the request to 0x20 is in flight
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h20,       0, 32'h0,        32'h24));
    vecs.push_back(mk(0, 1, 1, 32'h80,       0, 32'h0,        1, 32'h20,       0, 32'h0,        32'h24));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h20,       0, 32'h0,        32'h84));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hE0,       1, 32'h20,       0, 32'h0,        32'h84));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h80,       0, 32'h0,        32'h84));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hF0,       1, 32'h80,       1, 32'hF0,       32'h84));
    // repeated redirects while dropping: latest wins, ack+redirect together
    vecs.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        1, 32'h84,       0, 32'h0,        32'h88));
    vecs.push_back(mk(0, 1, 1, 32'h300,      0, 32'h0,        1, 32'h84,       0, 32'h0,        32'h204));
    vecs.push_back(mk(0, 1, 1, 32'h400,      1, 32'h77,       1, 32'h84,       0, 32'h0,        32'h304));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h400,      0, 32'h0,        32'h404));
    // wrap-around at the top of the address space
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFF8, 1, 32'h5,        1, 32'h400,      0, 32'h0,        32'h404));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h11,       1, 32'hFFFFFFF8, 1, 32'h11,       32'hFFFFFFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h12,       1, 32'hFFFFFFFC, 1, 32'h12,       32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h4));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].src, vecs[i].tgt,
                    vecs[i].ack, vecs[i].data);
      checkVector(i, vecs[i]);
    end

    // Reset asserted while a dropped request is still outstanding
    applyStimulus(0, 1, 1, 32'h40, 0, 32'h0);
    checkOutput("drop_entry_addr", imemAddr, 32'h0);
    applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
    checkOutput("drop_state_addr", imemAddr, 32'h0);
    checkOutput("drop_state_pc4", pcPlus4, 32'h44);
    applyStimulus(1, 1, 0, 32'h0, 1, 32'h66);
    checkOutput("rst_drop_req", {31'b0, imemReq}, 32'h0);
    checkOutput("rst_drop_valid", {31'b0, fetchValid}, 32'h0);
    checkOutput("rst_drop_pc4", pcPlus4, 32'h4);
    applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
    checkOutput("post_rst_req", {31'b0, imemReq}, 32'h1);
    checkOutput("post_rst_addr", imemAddr, 32'h0);

    // Bounded wait for the first delivery after reset
    begin
      bit got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h55);
        if (fetchValid) got = 1'b1;
      end
      checkOutput("post_rst_delivered", {31'b0, got}, 32'h1);
      if (got) begin
        checkOutput("post_rst_instr", instruction, 32'h55);
        checkOutput("post_rst_pc4", pcPlus4, 32'h4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
